ram: RTL and testbench

Dual-array on-chip memory for the 21-bit microprocessor, with separate instruction and data storage. Each array has its own address, its own write enable, its own read enable and its own registered output. Both arrays share one clock and one asynchronous reset. The block serves the fetch path (instruction array) and the load/store path (data array), and both can be accessed in the same cycle.

---
 rtl/ram.sv | 59 +++++
 tb/tb_ram.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ram.sv
// rtl/ram.sv - dual-array (instruction + data) on-chip memory with registered read ports
module ram #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 21,
  parameter int INST_WIDTH   = 21,
  parameter int NUM_MEM_ADDR = 2**ADDR_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Ram_Data_Read,
  input  logic                  Ram_Data_Write,
  input  logic                  Ram_Inst_Read,
  input  logic                  Ram_Inst_Write,
  input  logic [ADDR_WIDTH-1:0] Ram_Addr,
  input  logic [ADDR_WIDTH-1:0] Inst_Addr,
  input  logic [DATA_WIDTH-1:0] Ram_Data_In,
  input  logic [INST_WIDTH-1:0] Ram_Inst_In,
  output logic [DATA_WIDTH-1:0] Ram_Data_Out,
  output logic [INST_WIDTH-1:0] Ram_Inst_Out
);

  logic [DATA_WIDTH-1:0] data_mem [NUM_MEM_ADDR];
  logic [INST_WIDTH-1:0] inst_mem [NUM_MEM_ADDR];

  // Reset wipes the whole array, so storage is flops rather than an inferred RAM macro.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      data_mem <= '{default: '0};
    end else if (Ram_Data_Write) begin
      data_mem[Ram_Addr] <= Ram_Data_In;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      inst_mem <= '{default: '0};
    end else if (Ram_Inst_Write) begin
      inst_mem[Inst_Addr] <= Ram_Inst_In;
    end
  end

  // Write-first: a read colliding with a write returns the incoming word.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Ram_Data_Out <= '0;
    end else if (Ram_Data_Read) begin
      Ram_Data_Out <= Ram_Data_Write ? Ram_Data_In : data_mem[Ram_Addr];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Ram_Inst_Out <= '0;
    end else if (Ram_Inst_Read) begin
      Ram_Inst_Out <= Ram_Inst_Write ? Ram_Inst_In : inst_mem[Inst_Addr];
    end
  end

endmodule

// File: tb/tb_ram.sv
// tb/tb_ram.sv - scoreboard bench for ram
module tb_ram;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Ram_Data_Read = 1'b0, Ram_Data_Write = 1'b0;
  logic        Ram_Inst_Read = 1'b0, Ram_Inst_Write = 1'b0;
  logic [7:0]  Ram_Addr = '0, Inst_Addr = '0;
  logic [20:0] Ram_Data_In = '0, Ram_Inst_In = '0;
  logic [20:0] Ram_Data_Out, Ram_Inst_Out;

  ram dut (
    .Clk(Clk), .Reset(Reset),
    .Ram_Data_Read(Ram_Data_Read), .Ram_Data_Write(Ram_Data_Write),
    .Ram_Inst_Read(Ram_Inst_Read), .Ram_Inst_Write(Ram_Inst_Write),
    .Ram_Addr(Ram_Addr), .Inst_Addr(Inst_Addr),
    .Ram_Data_In(Ram_Data_In), .Ram_Inst_In(Ram_Inst_In),
    .Ram_Data_Out(Ram_Data_Out), .Ram_Inst_Out(Ram_Inst_Out)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [20:0] dmodel [256];
  logic [20:0] imodel [256];
  logic [20:0] dq [$];
  logic [20:0] iq [$];
  logic [20:0] dlast = '0, ilast = '0;

  task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %06h expected %06h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus; reads push expectations, results are popped after the edge.
  task automatic cyc(input logic dr, input logic dw, input logic [7:0] da, input logic [20:0] din,
                     input logic ir, input logic iw, input logic [7:0] ia, input logic [20:0] iin);
    @(negedge Clk);
    Ram_Data_Read = dr; Ram_Data_Write = dw; Ram_Addr = da; Ram_Data_In = din;
    Ram_Inst_Read = ir; Ram_Inst_Write = iw; Inst_Addr = ia; Ram_Inst_In = iin;
    if (dr) dq.push_back(dw ? din : dmodel[da]);
    if (dw) dmodel[da] = din;
    if (ir) iq.push_back(iw ? iin : imodel[ia]);
    if (iw) imodel[ia] = iin;
    @(posedge Clk);
    #1;
    if (dr) begin
      dlast = dq.pop_front();
      check("data_read", Ram_Data_Out, dlast);
    end else check("data_hold", Ram_Data_Out, dlast);
    if (ir) begin
      ilast = iq.pop_front();
      check("inst_read", Ram_Inst_Out, ilast);
    end else check("inst_hold", Ram_Inst_Out, ilast);
  endtask

  // Asynchronous reset with a write attempted at address wa during the reset edge.
  task automatic do_reset(input logic [7:0] wa);
    #2;
    Reset = 1'b1;
    #1;
    check("rst_data_out", Ram_Data_Out, 21'h0);
    check("rst_inst_out", Ram_Inst_Out, 21'h0);
    Ram_Data_Write = 1'b1; Ram_Addr = wa; Ram_Data_In = 21'h12345;
    Ram_Inst_Write = 1'b1; Inst_Addr = wa; Ram_Inst_In = 21'h0ABCD;
    Ram_Data_Read = 1'b1; Ram_Inst_Read = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    Ram_Data_Write = 1'b0; Ram_Inst_Write = 1'b0;
    Ram_Data_Read = 1'b0; Ram_Inst_Read = 1'b0;
    for (int i = 0; i < 256; i++) begin
      dmodel[i] = '0;
      imodel[i] = '0;
    end
    dlast = '0;
    ilast = '0;
  endtask

  initial begin
    logic [20:0] nv;
    for (int i = 0; i < 256; i++) begin
      dmodel[i] = '0;
      imodel[i] = '0;
    end
    #1;
    do_reset(8'd20);
    cyc(1, 0, 8'd0, 0, 1, 0, 8'd0, 0);
    cyc(1, 0, 8'd5, 0, 1, 0, 8'd5, 0);
    cyc(1, 0, 8'd255, 0, 1, 0, 8'd255, 0);
    cyc(1, 0, 8'd20, 0, 1, 0, 8'd20, 0);

    cyc(0, 1, 8'd3, 21'h0ABCDE, 0, 1, 8'd3, 21'h1F0F0F);
    cyc(1, 0, 8'd3, 0, 1, 0, 8'd3, 0);
    check("basic_data", Ram_Data_Out, 21'h0ABCDE);
    check("basic_inst", Ram_Inst_Out, 21'h1F0F0F);

    cyc(0, 1, 8'd7, 21'h000011, 0, 1, 8'd9, 21'h000022);
    cyc(1, 0, 8'd9, 0, 1, 0, 8'd7, 0);
    cyc(1, 0, 8'd7, 0, 1, 0, 8'd9, 0);
    check("indep_data", Ram_Data_Out, 21'h000011);
    check("indep_inst", Ram_Inst_Out, 21'h000022);

    cyc(1, 1, 8'd10, 21'h155555, 1, 1, 8'd10, 21'h0AAAAA);
    check("collide_data", Ram_Data_Out, 21'h155555);
    cyc(1, 0, 8'd10, 0, 1, 0, 8'd10, 0);

    cyc(0, 1, 8'd4, 21'h000444, 0, 1, 8'd4, 21'h000555);
    cyc(1, 0, 8'd3, 0, 1, 0, 8'd3, 0);
    cyc(0, 1, 8'd50, 21'h0DEAD, 0, 1, 8'd60, 21'h0BEEF);
    cyc(0, 0, 8'd4, 21'h1FFFFF, 0, 0, 8'd4, 21'h1FFFFF);
    cyc(0, 0, 8'd200, 0, 0, 0, 8'd201, 0);
    cyc(1, 0, 8'd4, 0, 1, 0, 8'd4, 0);
    check("nowrite_data", Ram_Data_Out, 21'h000444);
    cyc(1, 0, 8'd50, 0, 1, 0, 8'd60, 0);

    for (int a = 0; a < 256; a++) begin
      nv = ~{13'd0, 8'(a)};
      cyc(0, 1, 8'(a), 21'(a), 0, 1, 8'(a), nv);
    end
    for (int a = 0; a < 256; a++) cyc(1, 0, 8'(a), 0, 1, 0, 8'(255 - a), 0);
    for (int a = 0; a < 40; a++) cyc(1, 0, 8'(a * 7), 0, 0, 0, 8'd0, 0);
    do_reset(8'd128);
    cyc(1, 0, 8'd128, 0, 1, 0, 8'd128, 0);
    for (int a = 0; a < 256; a += 17) cyc(1, 0, 8'(a), 0, 1, 0, 8'(255 - a), 0);
    cyc(1, 0, 8'd255, 0, 1, 0, 8'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
